// File: rtl/cond_pkg.sv
// Shared types and constants for ARM condition evaluation and the NZCV flags.
package cond_pkg;

    typedef logic [3:0] flags_t;

    // Bit positions of the architectural flags inside flags_t ({N,Z,C,V}).
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition check: does cond pass against the given flags.
// Kept standalone so the branch predictor check can reuse it.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       pass
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign c_f = flags[FLAG_C];
    assign v_f = flags[FLAG_V];

    // Decode the condition field; the NV encoding is treated as always-pass here.
    always_comb begin
        pass = 1'b1;
        case (cond_e'(cond))
            EQ: pass = z_f;
            NE: pass = ~z_f;
            CS: pass = c_f;
            CC: pass = ~c_f;
            MI: pass = n_f;
            PL: pass = ~n_f;
            VS: pass = v_f;
            VC: pass = ~v_f;
            HI: pass = c_f & ~z_f;
            LS: pass = ~c_f | z_f;
            GE: pass = (n_f == v_f);
            LT: pass = (n_f != v_f);
            GT: pass = ~z_f & (n_f == v_f);
            LE: pass = z_f | (n_f != v_f);
            AL: pass = 1'b1;
            NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flags_unit.sv
// Architectural NZCV register plus condition gating of decoder write controls.
// Handshake: an instruction is present when valid_i=1; flush_i squashes it
// (same as valid_i=0); stall_i blocks the flag write and freezes the
// registered output stage. There is no ready/backpressure output.
module cond_flags_unit
    import cond_pkg::*;
#(
    parameter bit     REG_OUT     = 1'b0,
    parameter flags_t RESET_FLAGS = 4'b0000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic [3:0] cond_i,
    input  logic [1:0] flag_w_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       pc_src_i,
    input  logic [3:0] alu_flags_i,
    output logic       cond_ex_o,
    output logic       reg_w_o,
    output logic       mem_w_o,
    output logic       pc_src_o,
    output logic [3:0] flags_o
);

    flags_t     flags_q;
    flags_t     flags_d;
    logic       eff;
    logic       pass;
    logic       cond_ex;
    logic [3:0] gated;

    assign eff = valid_i & ~flush_i;

    // Condition is always judged against the committed flags, never the ALU's.
    cond_check u_cond_check (
        .cond  (cond_i),
        .flags (flags_q),
        .pass  (pass)
    );

    assign cond_ex = eff & pass;
    // Packed as {cond_ex, reg_w, mem_w, pc_src}.
    assign gated   = {cond_ex, reg_w_i & cond_ex, mem_w_i & cond_ex, pc_src_i & cond_ex};

    // Next flags: commit selected halves only for a passing, unstalled instruction.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && !stall_i) begin
            if (flag_w_i[1]) begin
                flags_d[FLAG_N] = alu_flags_i[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
            end
            if (flag_w_i[0]) begin
                flags_d[FLAG_C] = alu_flags_i[FLAG_C];
                flags_d[FLAG_V] = alu_flags_i[FLAG_V];
            end
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [3:0] out_q;
            logic [3:0] out_d;

            // Output stage: flush clears even under stall, stall holds, else load.
            always_comb begin
                out_d = out_q;
                if (flush_i) begin
                    out_d = 4'b0000;
                end else if (!stall_i) begin
                    out_d = gated;
                end
            end

            // Registered gated controls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= 4'b0000;
                end else begin
                    out_q <= out_d;
                end
            end

            assign {cond_ex_o, reg_w_o, mem_w_o, pc_src_o} = out_q;
        end else begin : g_comb_out
            assign {cond_ex_o, reg_w_o, mem_w_o, pc_src_o} = gated;
        end
    endgenerate

endmodule
